// File: rtl/time_display_if.sv
// Display bus between the countdown timer and the seven-segment driver.
// The timer side drives the value and status, the driver side returns seg/an.
interface time_display_if;
    logic [7:0] number;
    logic       timeout;
    logic       stop;
    logic [7:0] seg;
    logic [1:0] an;

    modport master (
        output number,
        output timeout,
        output stop,
        input  seg,
        input  an
    );

    modport slave (
        input  number,
        input  timeout,
        input  stop,
        output seg,
        output an
    );
endinterface

// File: rtl/time_display.sv
// Two-digit multiplexed seven-segment driver for the countdown clock,
// with leading-zero blanking, pause dot and timeout blink.
module time_display #(
    parameter int SCAN_DIV  = 25_000,
    parameter int GUARD     = 250,
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic          clk,
    input  logic          rst,
    time_display_if.slave bus
);
    typedef enum logic [1:0] {
        BLANK_A,
        SHOW_ONES,
        BLANK_B,
        SHOW_TENS
    } state_t;

    localparam logic [24:0] SCAN_LAST  = 25'(SCAN_DIV - 1);
    localparam logic [24:0] GUARD_LAST = 25'(GUARD - 1);
    localparam logic [24:0] BLINK_LAST = 25'(BLINK_DIV - 1);

    state_t      r_state;
    logic [24:0] r_dwell;
    logic [24:0] r_bcnt;
    logic        r_bon;
    logic [7:0]  r_num;
    logic        r_stop;
    logic        r_to;
    logic [7:0]  r_seg;
    logic [1:0]  r_an;

    state_t      w_state;
    logic [24:0] w_dwell;
    logic [24:0] w_bcnt;
    logic        w_bon;
    logic [7:0]  w_num;
    logic        w_stop;
    logic        w_to;
    logic [7:0]  w_seg;
    logic [1:0]  w_an;
    logic        w_term;
    logic        w_dark;
    logic [3:0]  w_nib;
    logic [7:0]  w_glyph;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BLANK_A;
            r_dwell <= '0;
            r_bcnt  <= '0;
            r_bon   <= 1'b1;
            r_num   <= '0;
            r_stop  <= 1'b0;
            r_to    <= 1'b0;
            r_seg   <= 8'hFF;
            r_an    <= 2'b11;
        end else begin
            r_state <= w_state;
            r_dwell <= w_dwell;
            r_bcnt  <= w_bcnt;
            r_bon   <= w_bon;
            r_num   <= w_num;
            r_stop  <= w_stop;
            r_to    <= w_to;
            r_seg   <= w_seg;
            r_an    <= w_an;
        end
    end

    always_comb begin
        w_state = r_state;
        w_term  = 1'b0;
        unique case (r_state)
            SHOW_ONES, SHOW_TENS: w_term = (r_dwell == SCAN_LAST);
            default:              w_term = (r_dwell == GUARD_LAST);
        endcase
        if (w_term) begin
            unique case (r_state)
                BLANK_A:   w_state = SHOW_ONES;
                SHOW_ONES: w_state = BLANK_B;
                BLANK_B:   w_state = SHOW_TENS;
                default:   w_state = BLANK_A;
            endcase
        end
        w_dwell = w_term ? '0 : r_dwell + 25'd1;

        // One snapshot per frame keeps both digits from the same value
        w_num  = r_num;
        w_stop = r_stop;
        w_to   = r_to;
        if (w_term && r_state == BLANK_A) begin
            w_num  = bus.number;
            w_stop = bus.stop;
            w_to   = bus.timeout;
        end

        w_bcnt = '0;
        w_bon  = 1'b1;
        if (bus.timeout) begin
            if (r_bcnt == BLINK_LAST) begin
                w_bcnt = '0;
                w_bon  = ~r_bon;
            end else begin
                w_bcnt = r_bcnt + 25'd1;
                w_bon  = r_bon;
            end
        end

        w_nib = (w_state == SHOW_TENS) ? w_num[7:4] : w_num[3:0];
        unique case (w_nib)
            4'd0:    w_glyph = 8'hC0;
            4'd1:    w_glyph = 8'hF9;
            4'd2:    w_glyph = 8'hA4;
            4'd3:    w_glyph = 8'hB0;
            4'd4:    w_glyph = 8'h99;
            4'd5:    w_glyph = 8'h92;
            4'd6:    w_glyph = 8'h82;
            4'd7:    w_glyph = 8'hF8;
            4'd8:    w_glyph = 8'h80;
            4'd9:    w_glyph = 8'h90;
            default: w_glyph = 8'hBF;
        endcase

        // Outputs follow the state being entered so they register in step
        w_dark = w_to && !w_bon;
        w_seg  = 8'hFF;
        w_an   = 2'b11;
        unique case (w_state)
            SHOW_ONES: begin
                if (!w_dark) begin
                    w_an  = 2'b10;
                    w_seg = w_glyph;
                end
            end
            SHOW_TENS: begin
                if (!w_dark) begin
                    if (w_num[7:4] != 4'd0) begin
                        w_an  = 2'b01;
                        w_seg = {~w_stop, w_glyph[6:0]};
                    end else if (w_stop) begin
                        w_an  = 2'b01;
                        w_seg = 8'h7F;
                    end
                end
            end
            default: begin
                w_seg = 8'hFF;
                w_an  = 2'b11;
            end
        endcase
    end

    assign bus.seg = r_seg;
    assign bus.an  = r_an;
endmodule
